// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Sequencer that adds two W-bit (W = 4*NIBBLES) 2's-complement operands
//   through one shared external 4-bit adder slice, one nibble per step. The
//   nibble inputs are held on the slice for SETTLE cycles so that the
//   gate-delay adder can settle. The nibble sum and carry are then captured,
//   and the carry is chained into the next nibble.
//
// Optional feature macro: SUB_EN
//   When defined, the block gains a 'sub' input. If sub is 1, the block
//   computes A - B by inverting the B nibbles and forcing the initial carry
//   to 1.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   start     in   request a new operation (only sampled while busy=0)
//   a, b      in   W-bit operands, latched on an accepted start
//   sub       in   (SUB_EN only) subtract select, latched with the operands
//   busy      out  operation in progress (RUN and DONE states)
//   done      out  one-cycle pulse; results are valid from this cycle on
//   sum       out  W-bit result, held until overwritten by the next run
//   carryout  out  carry out of the top nibble
//   overflow  out  signed overflow of the full-width operation
//   add_a     out  A nibble driven to the slice
//   add_b     out  B nibble (inverted when subtracting) driven to the slice
//   add_cin   out  carry-in driven to the slice
//   add_sum   in   slice nibble sum
//   add_cout  in   slice carry out of bit 3
//   add_c3    in   slice carry into bit 3 (used for overflow detection)

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4,
  parameter int SETTLE  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
`ifdef SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   carryout,
  output logic                   overflow,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  input  logic                   add_c3
);

  localparam int W    = 4 * NIBBLES;
  // Keep the counters at least 1 bit wide so that NIBBLES=1 and SETTLE=1 still elaborate.
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_reg, b_reg;
  logic [W-1:0]    sum_reg;
  logic            sub_reg;
  logic            sub_req;
  logic [IDXW-1:0] idx;
  logic [CNTW-1:0] cnt;
  logic            carry;
  logic            carryout_reg, overflow_reg;
  logic            step_end, last_nib;

`ifdef SUB_EN
  assign sub_req = sub;
`else
  assign sub_req = 1'b0;
`endif

  assign step_end = (state == RUN) && (cnt == CNT_LAST);
  assign last_nib = (idx == IDX_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. DONE always returns to IDLE, so a start that arrives
  // during the done cycle is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (step_end && last_nib) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. The slice inputs are decoded only from registered state,
  // so they stay stable for the whole settle window of each step.
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[idx*4 +: 4];
      add_b   = b_reg[idx*4 +: 4] ^ {4{sub_reg}};
      add_cin = carry;
    end
  end

  // Datapath. The operands are latched on accept, and one nibble is captured
  // per settle window. The carry and overflow flags change only at the
  // final capture, so they keep their previous values during a new run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sub_reg      <= 1'b0;
      sum_reg      <= '0;
      idx          <= '0;
      cnt          <= '0;
      carry        <= 1'b0;
      carryout_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub_req;
            idx     <= '0;
            cnt     <= '0;
            // Subtraction is A + ~B + 1, so the initial carry is the sub flag.
            carry   <= sub_req;
          end
        end
        RUN: begin
          if (cnt == CNT_LAST) begin
            sum_reg[idx*4 +: 4] <= add_sum;
            carry               <= add_cout;
            cnt                 <= '0;
            if (last_nib) begin
              carryout_reg <= add_cout;
              overflow_reg <= add_cout ^ add_c3;
            end else begin
              idx <= idx + IDXW'(1);
            end
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = sum_reg;
  assign carryout = carryout_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl
//   Directed bench for nibble_serial_add_ctrl. It uses a default instance
//   (NIBBLES=4, SETTLE=1) and a second instance with SETTLE=3. Each instance
//   is paired with a behavioural 4-bit adder slice model.

`timescale 1ns/1ps

module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  int          total = 0;
  int          bad = 0;

  // Default instance signals.
  logic        start;
  logic [15:0] a, b;
  logic        busy, done, carryout, overflow;
  logic [15:0] sum;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout, add_c3;
  logic [4:0]  full5;
  logic [3:0]  low4;

  // SETTLE=3 instance signals.
  logic        s3_start;
  logic [15:0] s3_a, s3_b;
  logic        s3_busy, s3_done, s3_carryout, s3_overflow;
  logic [15:0] s3_sum;
  logic [3:0]  s3_add_a, s3_add_b, s3_add_sum;
  logic        s3_add_cin, s3_add_cout, s3_add_c3;
  logic [4:0]  s3_full5;
  logic [3:0]  s3_low4;

`ifdef SUB_EN
  logic        sub;
  logic        s3_sub = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural slice models: nibble sum, carry out of bit 3, carry into bit 3.
  assign full5       = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign low4        = {1'b0, add_a[2:0]} + {1'b0, add_b[2:0]} + {3'b0, add_cin};
  assign add_sum     = full5[3:0];
  assign add_cout    = full5[4];
  assign add_c3      = low4[3];

  assign s3_full5    = {1'b0, s3_add_a} + {1'b0, s3_add_b} + {4'b0, s3_add_cin};
  assign s3_low4     = {1'b0, s3_add_a[2:0]} + {1'b0, s3_add_b[2:0]} + {3'b0, s3_add_cin};
  assign s3_add_sum  = s3_full5[3:0];
  assign s3_add_cout = s3_full5[4];
  assign s3_add_c3   = s3_low4[3];

  nibble_serial_add_ctrl #(.NIBBLES(4), .SETTLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
`ifdef SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .carryout(carryout), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_c3(add_c3)
  );

  nibble_serial_add_ctrl #(.NIBBLES(4), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(s3_start), .a(s3_a), .b(s3_b),
`ifdef SUB_EN
    .sub(s3_sub),
`endif
    .busy(s3_busy), .done(s3_done), .sum(s3_sum), .carryout(s3_carryout),
    .overflow(s3_overflow),
    .add_a(s3_add_a), .add_b(s3_add_b), .add_cin(s3_add_cin),
    .add_sum(s3_add_sum), .add_cout(s3_add_cout), .add_c3(s3_add_c3)
  );

  // Issue one operation on the default instance. The task returns at the
  // negedge where done is seen, or after a bounded number of edges. The
  // operands are scrambled after acceptance to show that they were latched.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, output int edges);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    edges = 0;
    while (done !== 1'b1 && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; s3_start = 1'b0;
    a = 16'h0; b = 16'h0; s3_a = 16'h0; s3_b = 16'h0;
`ifdef SUB_EN
    sub = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    total++;
    if ({busy, done, carryout, overflow, sum, add_a, add_b, add_cin} !== 31'd0) begin
      bad++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b sum=%h co=%b ov=%b a=%h b=%h cin=%b, want all 0",
               busy, done, sum, carryout, overflow, add_a, add_b, add_cin);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int edges;
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_busy: got busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    edges = 0;
    while (done !== 1'b1 && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    total++;
    if (edges !== 4) begin
      bad++;
      $display("[TB] FAIL basic_latency: got %0d edges, want 4", edges);
    end
    total++;
    if (sum !== 16'h0002 || carryout !== 1'b0 || overflow !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_result: got sum=%h co=%b ov=%b busy=%b, want 0002 0 0 1",
               sum, carryout, overflow, busy);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_pulse: got done=%b busy=%b after done cycle, want 0 0", done, busy);
    end
  endtask

  task automatic test_overflow();
    int edges;
    do_op(16'h7FFF, 16'h0001, edges);
    total++;
    if (edges !== 4 || sum !== 16'h8000 || carryout !== 1'b0 || overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_7fff: got edges=%0d sum=%h co=%b ov=%b, want 4 8000 0 1",
               edges, sum, carryout, overflow);
    end
    do_op(16'hFFFF, 16'h0001, edges);
    total++;
    if (edges !== 4 || sum !== 16'h0000 || carryout !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ovf_ffff: got edges=%0d sum=%h co=%b ov=%b, want 4 0000 1 0",
               edges, sum, carryout, overflow);
    end
    // The flags must keep their prior values while a new run is in progress.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if (carryout !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flags_hold: got co=%b busy=%b mid-run, want 1 1", carryout, busy);
    end
    edges = 0;
    while (done !== 1'b1 && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    total++;
    if (sum !== 16'h0002 || carryout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flags_after: got sum=%h co=%b, want 0002 0", sum, carryout);
    end
    do_op(16'h8000, 16'h8000, edges);
    total++;
    if (edges !== 4 || sum !== 16'h0000 || carryout !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_8000: got edges=%0d sum=%h co=%b ov=%b, want 4 0000 1 1",
               edges, sum, carryout, overflow);
    end
  endtask

  task automatic test_settle();
    logic [15:0] av;
    logic [15:0] bv;
    logic [3:0]  cinv;
    int          step;
    int          edges;
    av = 16'h8F29; bv = 16'h8019; cinv = 4'b0010;
    @(negedge clk);
    s3_a = av; s3_b = bv; s3_start = 1'b1;
    @(posedge clk); @(negedge clk);
    s3_start = 1'b0; s3_a = 16'h0; s3_b = 16'h0;
    for (int k = 0; k < 12; k++) begin
      step = k / 3;
      total++;
      if (s3_add_a !== av[step*4 +: 4] || s3_add_b !== bv[step*4 +: 4] ||
          s3_add_cin !== cinv[step] || s3_done !== 1'b0 || s3_busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL settle_hold_%0d: got a=%h b=%h cin=%b done=%b busy=%b, want %h %h %b 0 1",
                 k, s3_add_a, s3_add_b, s3_add_cin, s3_done, s3_busy,
                 av[step*4 +: 4], bv[step*4 +: 4], cinv[step]);
      end
      @(posedge clk); @(negedge clk);
    end
    total++;
    if (s3_done !== 1'b1 || s3_sum !== 16'h0F42 || s3_carryout !== 1'b1 || s3_overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL settle_result: got done=%b sum=%h co=%b ov=%b, want 1 0f42 1 1",
               s3_done, s3_sum, s3_carryout, s3_overflow);
    end
    @(negedge clk);
    s3_a = 16'h8000; s3_b = 16'h8000; s3_start = 1'b1;
    @(posedge clk); @(negedge clk);
    s3_start = 1'b0;
    edges = 0;
    while (s3_done !== 1'b1 && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    total++;
    if (edges !== 12 || s3_sum !== 16'h0000 || s3_carryout !== 1'b1 || s3_overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL settle_8000: got edges=%0d sum=%h co=%b ov=%b, want 12 0000 1 1",
               edges, s3_sum, s3_carryout, s3_overflow);
    end
  endtask

  task automatic test_start_held();
    int dones;
    int cyc;
    @(negedge clk);
    a = 16'h1234; b = 16'h0F0F; start = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 16'h5555; b = 16'h3333;
    dones = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 50) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    if (done === 1'b1) dones++;
    total++;
    if (sum !== 16'h2143) begin
      bad++;
      $display("[TB] FAIL held_result: got sum=%h, want 2143", sum);
    end
    // Start is still high through the done-cycle edge, so it must be ignored there.
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL held_done_ignore: got busy=%b after done cycle, want 0", busy);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("[TB] FAIL held_done_count: got %0d done pulses, want 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int edges;
    @(negedge clk);
    a = 16'h00FF; b = 16'h0011; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, carryout, overflow, sum, add_a, add_b, add_cin} !== 31'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid: got busy=%b done=%b sum=%h co=%b ov=%b a=%h b=%h cin=%b, want all 0",
               busy, done, sum, carryout, overflow, add_a, add_b, add_cin);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("[TB] FAIL reset_no_done: got %0d busy/done cycles after reset, want 0", dones);
    end
    do_op(16'h000A, 16'h0006, edges);
    total++;
    if (edges !== 4 || sum !== 16'h0010 || carryout !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_recover: got edges=%0d sum=%h co=%b ov=%b, want 4 0010 0 0",
               edges, sum, carryout, overflow);
    end
  endtask

`ifdef SUB_EN
  task automatic test_sub();
    int edges;
    sub = 1'b1;
    do_op(16'h0005, 16'h0007, edges);
    total++;
    if (edges !== 4 || sum !== 16'hFFFE || carryout !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sub_5m7: got edges=%0d sum=%h co=%b ov=%b, want 4 fffe 0 0",
               edges, sum, carryout, overflow);
    end
    do_op(16'h8000, 16'h0001, edges);
    total++;
    if (edges !== 4 || sum !== 16'h7FFF || carryout !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sub_8000m1: got edges=%0d sum=%h co=%b ov=%b, want 4 7fff 1 1",
               edges, sum, carryout, overflow);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_settle();
    test_start_held();
    test_reset_mid();
`ifdef SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
